// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
package uart_tx_mmio_pkg;

   // Bus word offsets
   localparam logic [1:0] UART_DATA   = 2'd0;
   localparam logic [1:0] UART_STATUS = 2'd1;

   // STATUS word bit positions
   localparam int ST_BUSY    = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_EMPTY   = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_LVL_LSB = 4;
   localparam int ST_LVL_W   = 5;

   // Frame engine states
   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Single-clock FIFO; dout shows the head entry whenever the FIFO is non-empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_level;
   logic             w_push;
   logic             w_pop;

   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;
   assign full   = (r_level == (AW+1)'(DEPTH));
   assign empty  = (r_level == '0);
   assign level  = r_level;
   assign dout   = r_mem[r_rptr];

   // Storage array needs no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two; level is kept separately.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// UART 8N1 transmitter with a bus-visible TX FIFO and polled STATUS word.
//
// state    | meaning
// TX_IDLE  | line high, waiting for a byte in the FIFO
// TX_START | start bit (low) for one bit period
// TX_DATA  | eight data bits, LSB first
// TX_STOP  | stop bit (high); chains directly into the next start bit
module uart_tx_mmio
   import uart_tx_mmio_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [1:0]  io_addr,
   input  logic [31:0] io_wdata,
   input  logic        io_wstrb,
   input  logic        io_rstrb,
   output logic [31:0] io_rdata,
   output logic        TXD,
   output logic        tx_busy
);

   localparam int              BW        = $clog2(CLKS_PER_BIT);
   localparam int              LW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   tx_state_e   r_state, w_state_nxt;
   logic [BW-1:0] r_baud, w_baud_nxt;
   logic [2:0]  r_bit_idx, w_bit_idx_nxt;
   logic [7:0]  r_shift, w_shift_nxt;
   logic        r_txd, w_txd_nxt;
   logic        r_ovf;
   logic [31:0] r_rdata;

   logic        w_fifo_full, w_fifo_empty, w_push, w_pop, w_bit_end;
   logic        w_store_data, w_store_status;
   logic [7:0]  w_fifo_dout;
   logic [LW-1:0] w_fifo_level;
   logic [31:0] w_status;
   logic        w_unused_wdata;

   assign w_unused_wdata = ^io_wdata[31:8];

   assign w_store_data   = io_wstrb & (io_addr == UART_DATA);
   assign w_store_status = io_wstrb & (io_addr == UART_STATUS);
   // Full is the registered value, so a store racing a pop from a full FIFO is dropped.
   assign w_push         = w_store_data & ~w_fifo_full;
   assign w_bit_end      = (r_baud == BAUD_LAST);

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (w_push),
      .pop    (w_pop),
      .din    (io_wdata[7:0]),
      .dout   (w_fifo_dout),
      .full   (w_fifo_full),
      .empty  (w_fifo_empty),
      .level  (w_fifo_level)
   );

   // STATUS word assembled from registered state only.
   always_comb begin
      w_status                             = '0;
      w_status[ST_BUSY]                    = (r_state != TX_IDLE);
      w_status[ST_FULL]                    = w_fifo_full;
      w_status[ST_EMPTY]                   = w_fifo_empty;
      w_status[ST_OVF]                     = r_ovf;
      w_status[ST_LVL_LSB +: ST_LVL_W]     = ST_LVL_W'(w_fifo_level);
   end

   // Frame engine next-state, counters, shift register and FIFO pop.
   always_comb begin
      w_state_nxt   = r_state;
      w_baud_nxt    = r_baud;
      w_bit_idx_nxt = r_bit_idx;
      w_shift_nxt   = r_shift;
      w_pop         = 1'b0;
      case (r_state)
         TX_IDLE: begin
            if (!w_fifo_empty) begin
               w_pop       = 1'b1;
               w_shift_nxt = w_fifo_dout;
               w_baud_nxt  = '0;
               w_state_nxt = TX_START;
            end
         end
         TX_START: begin
            if (w_bit_end) begin
               w_baud_nxt    = '0;
               w_bit_idx_nxt = '0;
               w_state_nxt   = TX_DATA;
            end else begin
               w_baud_nxt = r_baud + 1'b1;
            end
         end
         TX_DATA: begin
            if (w_bit_end) begin
               w_baud_nxt    = '0;
               w_shift_nxt   = {1'b0, r_shift[7:1]};
               w_bit_idx_nxt = r_bit_idx + 1'b1;
               if (r_bit_idx == 3'd7) w_state_nxt = TX_STOP;
            end else begin
               w_baud_nxt = r_baud + 1'b1;
            end
         end
         TX_STOP: begin
            if (w_bit_end) begin
               w_baud_nxt = '0;
               if (!w_fifo_empty) begin
                  w_pop       = 1'b1;
                  w_shift_nxt = w_fifo_dout;
                  w_state_nxt = TX_START;
               end else begin
                  w_state_nxt = TX_IDLE;
               end
            end else begin
               w_baud_nxt = r_baud + 1'b1;
            end
         end
         default: w_state_nxt = TX_IDLE;
      endcase
   end

   // Line level is decoded from the next state so TXD changes on the same edge as the state.
   always_comb begin
      case (w_state_nxt)
         TX_START: w_txd_nxt = 1'b0;
         TX_DATA:  w_txd_nxt = w_shift_nxt[0];
         default:  w_txd_nxt = 1'b1;
      endcase
   end

   // Frame engine registers, including the TXD output flop.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= TX_IDLE;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_txd     <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_baud    <= w_baud_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_shift   <= w_shift_nxt;
         r_txd     <= w_txd_nxt;
      end
   end

   // Sticky overflow: set by a dropped store, cleared by any store to STATUS.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                          r_ovf <= 1'b0;
      else if (w_store_data && w_fifo_full) r_ovf <= 1'b1;
      else if (w_store_status)              r_ovf <= 1'b0;
   end

   // Registered load data; holds between loads and sees pre-store status.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)       r_rdata <= '0;
      else if (io_rstrb) r_rdata <= (io_addr == UART_STATUS) ? w_status : 32'd0;
   end

   assign io_rdata = r_rdata;
   assign TXD      = r_txd;
   assign tx_busy  = (r_state != TX_IDLE) | ~w_fifo_empty;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: expected bytes and load values go into queues; independent
// monitors decode TXD frames and load responses and compare against them.
module tb_uart_tx_mmio;

   localparam int CPB = 4;
   localparam int DEP = 4;
   localparam int FRAME = 10 * CPB;

   logic        clk = 1'b0;
   logic        resetn;
   logic [1:0]  io_addr;
   logic [31:0] io_wdata;
   logic        io_wstrb;
   logic        io_rstrb;
   logic [31:0] io_rdata;
   logic        TXD;
   logic        tx_busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0]  tx_q[$];
   int          q_starts[$];
   bit          rd_chk_q[$];
   logic [31:0] rd_exp_q[$];

   uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .io_addr  (io_addr),
      .io_wdata (io_wdata),
      .io_wstrb (io_wstrb),
      .io_rstrb (io_rstrb),
      .io_rdata (io_rdata),
      .TXD      (TXD),
      .tx_busy  (tx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
      end
   endtask

   task automatic drive(input bit w, input bit r, input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      io_wstrb = w;
      io_rstrb = r;
      io_addr  = a;
      io_wdata = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'd0, 32'd0);
   endtask

   task automatic load(input logic [1:0] a, input bit chk, input logic [31:0] exp);
      drive(1'b0, 1'b1, a, 32'd0);
      rd_chk_q.push_back(chk);
      rd_exp_q.push_back(exp);
   endtask

   task automatic wait_idle(input string name, output int t_end);
      int n;
      n = 0;
      drive(1'b0, 1'b0, 2'd0, 32'd0);
      while ((tx_q.size() != 0 || tx_busy !== 1'b0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      t_end = cyc;
      check({name, "_idle"}, {31'd0, tx_busy}, 32'd0);
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return b[k-1];
   endfunction

   // Load monitor: one cycle after each accepted load, compare io_rdata.
   initial begin
      forever begin
         @(posedge clk);
         if (io_rstrb === 1'b1 && resetn === 1'b1) begin
            @(negedge clk);
            if (rd_exp_q.size() > 0) begin
               logic [31:0] e;
               bit c;
               e = rd_exp_q.pop_front();
               c = rd_chk_q.pop_front();
               if (c) check("load", io_rdata, e);
            end
         end
      end
   end

   // Frame monitor: every cycle of a 40-cycle frame must carry the expected bit level.
   initial begin
      forever begin
         @(negedge clk);
         if (resetn === 1'b1 && TXD === 1'b0) begin
            logic [7:0] e;
            logic [7:0] got;
            bit have, ok, aborted;
            q_starts.push_back(cyc);
            have = (tx_q.size() > 0);
            e = have ? tx_q.pop_front() : 8'h00;
            ok = 1'b1;
            aborted = 1'b0;
            got = 8'h00;
            for (int j = 0; j < FRAME; j++) begin
               if (j > 0) @(negedge clk);
               if (resetn !== 1'b1) begin
                  aborted = 1'b1;
                  break;
               end
               if (TXD !== frame_bit(e, j / CPB)) ok = 1'b0;
               if ((j % CPB) == CPB / 2 && (j / CPB) >= 1 && (j / CPB) <= 8)
                  got[(j / CPB) - 1] = TXD;
            end
            if (!aborted) begin
               total++;
               if (!have) begin
                  bad++;
                  $display("FAIL frame unexpected got=0x%0h exp=none", got);
               end else if (!ok || got !== e) begin
                  bad++;
                  $display("FAIL frame got=0x%0h exp=0x%0h timing_ok=%0d", got, e, ok);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t_end, n, low;
      logic [7:0] b;
      resetn   = 1'b0;
      io_wstrb = 1'b0;
      io_rstrb = 1'b0;
      io_addr  = 2'd0;
      io_wdata = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_txd", {31'd0, TXD}, 32'd1);
      check("rst_rdata", io_rdata, 32'd0);
      check("rst_busy", {31'd0, tx_busy}, 32'd0);
      resetn = 1'b1;
      idle(2);

      // Status poll on an empty idle block, plus DATA/reserved reads and hold.
      load(2'd0, 1'b1, 32'd0);
      load(2'd1, 1'b1, 32'h4);
      idle(4);
      check("rdata_hold", io_rdata, 32'h4);
      load(2'd3, 1'b1, 32'd0);

      // Single byte: start edge two edges after the store, 40-cycle frame.
      q_starts.delete();
      drive(1'b1, 1'b0, 2'd0, 32'h55);
      tx_q.push_back(8'h55);
      idle(1);
      check("lat_push_edge", {31'd0, TXD}, 32'd1);
      idle(1);
      check("lat_pop_edge", {31'd0, TXD}, 32'd0);
      wait_idle("single", t_end);
      check("single_len", (q_starts.size() > 0) ? t_end - q_starts[0] : -1, FRAME);

      // Back-to-back frames with no gap; busy drops right after the second stop bit.
      q_starts.delete();
      drive(1'b1, 1'b0, 2'd0, 32'h00);
      tx_q.push_back(8'h00);
      drive(1'b1, 1'b0, 2'd0, 32'hFF);
      tx_q.push_back(8'hFF);
      wait_idle("b2b", t_end);
      check("b2b_gap", (q_starts.size() > 1) ? q_starts[1] - q_starts[0] : -1, FRAME);
      check("b2b_busy_fall", (q_starts.size() > 0) ? t_end - q_starts[0] : -1, 2 * FRAME);

      // Overflow: first byte goes to the engine, four queue, sixth dropped.
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom);
         drive(1'b1, 1'b0, 2'd0, {24'd0, b});
         if (i < 5) tx_q.push_back(b);
      end
      load(2'd1, 1'b1, 32'h4B);
      // Load and store to STATUS together: load sees overflow still set, store clears it.
      drive(1'b1, 1'b1, 2'd1, 32'd0);
      rd_chk_q.push_back(1'b1);
      rd_exp_q.push_back(32'h4B);
      load(2'd1, 1'b1, 32'h43);
      wait_idle("ovf", t_end);

      // Concurrent load+store at DATA on an empty FIFO: DATA reads 0, the byte is sent,
      // and the following STATUS loads see the pre-pop then post-pop state.
      drive(1'b1, 1'b1, 2'd0, 32'h3C);
      rd_chk_q.push_back(1'b1);
      rd_exp_q.push_back(32'd0);
      tx_q.push_back(8'h3C);
      load(2'd1, 1'b1, 32'h10);
      load(2'd1, 1'b1, 32'h05);
      wait_idle("concurrent", t_end);

      // Random traffic with flow control by polling; stores to reserved offsets must not send.
      for (int k = 0; k < 12; k++) begin
         idle($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0)
            drive(1'b1, 1'b0, 2'($urandom_range(2, 3)), $urandom);
         n = 0;
         do begin
            load(2'd1, 1'b0, 32'd0);
            idle(1);
            n++;
         end while (io_rdata[1] === 1'b1 && n < 200);
         b = 8'($urandom);
         drive(1'b1, 1'b0, 2'd0, {$urandom_range(0, 255), b});
         tx_q.push_back(b);
      end
      wait_idle("random", t_end);

      // Reset during data bit 3 of 0xA5 aborts the frame at once.
      drive(1'b1, 1'b0, 2'd0, 32'hA5);
      tx_q.push_back(8'hA5);
      idle(1);
      n = 0;
      while (TXD !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("a5_start", {31'd0, TXD}, 32'd0);
      repeat (17) @(negedge clk);
      check("a5_bit3", {31'd0, TXD}, 32'd0);
      #1 resetn = 1'b0;
      #1;
      check("async_rst_txd", {31'd0, TXD}, 32'd1);
      check("async_rst_busy", {31'd0, tx_busy}, 32'd0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      load(2'd1, 1'b1, 32'h4);
      low = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (TXD !== 1'b1) low++;
      end
      check("no_frame_after_rst", low, 0);
      check("busy_after_rst", {31'd0, tx_busy}, 32'd0);

      idle(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
